// File: rtl/countdown_ctrl.sv
// countdown_ctrl: responder side of the menu start handshake.
// Holds the menu confirm line through a COUNT_FROM..1 countdown followed by a
// GO banner, then releases it so the menu advances to PLAY. Also drives the
// digit/GO overlay indicators and a one-cycle done pulse.
// Optional build macro: COUNTDOWN_SKIP_EN -- a fresh press during the
// countdown jumps straight to GO.
module countdown_ctrl #(
    parameter int TICKS_PER_SEC = 60,  // 2..255
    parameter int COUNT_FROM    = 3,   // 1..9
    parameter int GO_TICKS      = 30   // 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_press,
    input  logic       menu_active,
    input  logic       countdown_active,
    output logic       confirm_out,
    output logic [3:0] digit,
    output logic       show_digit,
    output logic       show_go,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_GO,
        S_DONE
    } state_t;

    localparam logic [7:0] TICK_LAST   = 8'(TICKS_PER_SEC - 1);
    localparam logic [7:0] GO_LAST     = 8'(GO_TICKS - 1);
    localparam logic [3:0] DIGIT_FIRST = 4'(COUNT_FROM);

    state_t     state;
    logic [7:0] tick;
    logic       btn_q;
    logic       press_rise;

    // btn_q powers up high, so a button held through reset never looks like a press
    assign press_rise = btn_press & ~btn_q;

    // handshake FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tick        <= 8'd0;
            btn_q       <= 1'b1;
            confirm_out <= 1'b0;
            digit       <= 4'd0;
            show_digit  <= 1'b0;
            show_go     <= 1'b0;
            done        <= 1'b0;
        end else begin
            btn_q <= btn_press;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    confirm_out <= 1'b0;
                    show_digit  <= 1'b0;
                    show_go     <= 1'b0;
                    // only arm while the menu is showing; presses in PLAY are dropped
                    if (press_rise && menu_active) begin
                        state       <= S_ARM;
                        tick        <= 8'd0;
                        confirm_out <= 1'b1;
                    end
                end

                S_ARM: begin
                    if (countdown_active) begin
                        state      <= S_COUNT;
                        tick       <= 8'd0;
                        digit      <= DIGIT_FIRST;
                        show_digit <= 1'b1;
                    end else if (!menu_active) begin
                        // menu was reset or has already moved on
                        state       <= S_IDLE;
                        tick        <= 8'd0;
                        confirm_out <= 1'b0;
                    end
                end

                S_COUNT: begin
                    // abort wins over both the skip press and tick expiry
                    if (!countdown_active) begin
                        state       <= S_IDLE;
                        tick        <= 8'd0;
                        digit       <= 4'd0;
                        confirm_out <= 1'b0;
                        show_digit  <= 1'b0;
                        show_go     <= 1'b0;
`ifdef COUNTDOWN_SKIP_EN
                    end else if (press_rise) begin
                        state       <= S_GO;
                        tick        <= 8'd0;
                        digit       <= 4'd0;
                        confirm_out <= 1'b0;
                        show_digit  <= 1'b0;
                        show_go     <= 1'b1;
`endif
                    end else if (tick == TICK_LAST) begin
                        tick <= 8'd0;
                        if (digit == 4'd1) begin
                            // dropping confirm here lets the menu enter PLAY
                            state       <= S_GO;
                            digit       <= 4'd0;
                            confirm_out <= 1'b0;
                            show_digit  <= 1'b0;
                            show_go     <= 1'b1;
                        end else begin
                            digit <= digit - 4'd1;
                        end
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end

                S_GO: begin
                    // GO banner stays up for exactly GO_TICKS cycles
                    if (tick == GO_LAST) begin
                        state   <= S_DONE;
                        tick    <= 8'd0;
                        show_go <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    tick  <= 8'd0;
                end

                default: begin
                    state       <= S_IDLE;
                    tick        <= 8'd0;
                    digit       <= 4'd0;
                    confirm_out <= 1'b0;
                    show_digit  <= 1'b0;
                    show_go     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: one instance with default timing and one
// with short timing (4/1/2). Expected values are hand-derived cycle counts.
module tb_countdown_ctrl;

    logic clk = 1'b0;
    logic reset;

    logic btn, menu, cd;
    logic confirm, show_digit, show_go, done;
    logic [3:0] digit;

    logic s_btn, s_menu, s_cd;
    logic s_confirm, s_show_digit, s_show_go, s_done;
    logic [3:0] s_digit;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_ctrl dut (
        .clk(clk), .reset(reset), .btn_press(btn), .menu_active(menu),
        .countdown_active(cd), .confirm_out(confirm), .digit(digit),
        .show_digit(show_digit), .show_go(show_go), .done(done)
    );

    countdown_ctrl #(.TICKS_PER_SEC(4), .COUNT_FROM(1), .GO_TICKS(2)) dut_s (
        .clk(clk), .reset(reset), .btn_press(s_btn), .menu_active(s_menu),
        .countdown_active(s_cd), .confirm_out(s_confirm), .digit(s_digit),
        .show_digit(s_show_digit), .show_go(s_show_go), .done(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then sit 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_main();
        btn = 1'b0; step(1);
        btn = 1'b1; step(1);
    endtask

    task automatic press_small();
        s_btn = 1'b0; step(1);
        s_btn = 1'b1; step(1);
    endtask

    int done_seen;

    initial begin
        reset = 1'b1;
        btn = 1'b1; menu = 1'b0; cd = 1'b0;
        s_btn = 1'b0; s_menu = 1'b0; s_cd = 1'b0;
        #2;
        chk("rst_confirm", confirm, 0);
        chk("rst_digit", digit, 0);
        chk("rst_show", {show_digit, show_go, done}, 0);
        step(2);
        reset = 1'b0;

        // button held straight through reset must not arm
        menu = 1'b1;
        step(3);
        chk("held_no_arm", confirm, 0);

        // press -> confirm one edge later
        press_main();
        chk("arm_confirm", confirm, 1);
        chk("arm_no_digit", show_digit, 0);
        cd = 1'b1;
        step(1);
        chk("count_d3", digit, 3);
        chk("count_show", {confirm, show_digit, show_go}, 3'b110);
        step(59);
        chk("d3_last", digit, 3);
        step(1);
        chk("d2_first", digit, 2);
        step(60);
        chk("d1_first", digit, 1);
        step(59);
        chk("d1_last", {digit, show_go}, {4'd1, 1'b0});
        step(1);
        chk("go_enter", {confirm, show_digit, show_go}, 3'b001);
        chk("go_digit", digit, 0);
        menu = 1'b0; cd = 1'b0;
        step(29);
        chk("go_last", {show_go, done}, 2'b10);
        step(1);
        chk("done_pulse", {show_go, done}, 2'b01);
        step(1);
        chk("done_clear", done, 0);

        // presses during PLAY are ignored
        press_main();
        step(1);
        chk("play_press", confirm, 0);

        // ARM abandoned when menu leaves without countdown
        menu = 1'b1;
        press_main();
        chk("arm2", confirm, 1);
        menu = 1'b0;
        step(1);
        chk("arm_abort", confirm, 0);

        // abort in the middle of digit 2
        menu = 1'b1;
        press_main();
        cd = 1'b1;
        step(61);
        chk("abort_pre_d2", digit, 2);
        cd = 1'b0;
        step(1);
        chk("abort_out", {confirm, show_digit, digit}, 6'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (done === 1'b1) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        // press during digit 3
        btn = 1'b0;
        press_main();
        cd = 1'b1;
        step(5);
        press_main();
`ifdef COUNTDOWN_SKIP_EN
        chk("skip_go", {confirm, show_digit, show_go}, 3'b001);
        chk("skip_digit", digit, 0);
        cd = 1'b0; menu = 1'b0;
        step(29);
        chk("skip_go_last", {show_go, done}, 2'b10);
        step(1);
        chk("skip_done", done, 1);
`else
        chk("noskip_digit", digit, 3);
        chk("noskip_show", {confirm, show_digit, show_go}, 3'b110);
        cd = 1'b0; menu = 1'b0;
        step(1);
`endif
        step(2);

        // short-timing instance: digit 1 for 4 cycles, GO for 2, done 1 cycle
        s_menu = 1'b1;
        press_small();
        chk("s_arm", s_confirm, 1);
        s_cd = 1'b1;
        step(1);
        chk("s_d1", {s_show_digit, s_digit}, {1'b1, 4'd1});
        step(3);
        chk("s_d1_last", {s_show_digit, s_show_go}, 2'b10);
        step(1);
        chk("s_go", {s_confirm, s_show_digit, s_show_go, s_digit}, {3'b001, 4'd0});
        s_cd = 1'b0; s_menu = 1'b0;
        step(1);
        chk("s_go_last", {s_show_go, s_done}, 2'b10);
        step(1);
        chk("s_done", {s_show_go, s_done}, 2'b01);
        step(1);
        chk("s_done_clear", s_done, 0);

        // run into GO again and hit reset between clock edges
        s_menu = 1'b1;
        press_small();
        s_cd = 1'b1;
        step(5);
        chk("s_go2", s_show_go, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", {s_confirm, s_show_digit, s_show_go, s_done, s_digit}, 8'd0);
        chk("async_rst_main", {confirm, show_digit, show_go, done, digit}, 8'd0);
        step(1);
        reset = 1'b0;
        s_cd = 1'b0; s_menu = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Responder side of the menu start handshake. Drives the menu's confirm line: raises it on a P1 press in MENU, holds it through a 3-2-1-GO countdown, then drops it so the menu FSM advances COUNTDOWN -> PLAY. Also supplies digit/GO indicators to the VGA overlay. Runs on the 60 Hz game clock.

Parameters:
TICKS_PER_SEC, 60, clk cycles per displayed digit (legal range 2..255).
COUNT_FROM, 3, first digit shown (legal range 1..9).
GO_TICKS, 30, clk cycles GO is shown (legal range 1..255).

Ports:
clk  in  1  60 Hz game clock.
reset  in  1  asynchronous, active-high.
btn_press  in  1  P1 confirm button level, already synchronised.
menu_active  in  1  menu FSM is in MENU.
countdown_active  in  1  menu FSM is in COUNTDOWN.
confirm_out  out  1  drives the menu FSM confirm input.
digit  out  4  current countdown digit, binary 0..9.
show_digit  out  1  overlay should draw digit.
show_go  out  1  overlay should draw "GO".
done  out  1  one-cycle pulse on GO completion.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset forces state=IDLE, confirm_out=0, digit=0, show_digit=0, show_go=0, done=0, tick counter=0, btn_q=1.
- btn_q resets to 1 so a button held through reset does not arm. Rising edge is press_rise = btn_press & ~btn_q. btn_q <= btn_press every cycle.
- All outputs are registered and change on the clk edge after the causing condition.
- The tick counter is 8 bits. It clears on every state entry.
- IDLE: confirm_out=0, show_digit=0, show_go=0.
  - press_rise & menu_active -> ARM.
  - press_rise without menu_active is ignored.
- ARM: confirm_out=1, show_digit=0, show_go=0.
  - countdown_active -> COUNT, with digit=COUNT_FROM and tick=0.
  - If !menu_active & !countdown_active (menu reset or already in PLAY) -> IDLE, confirm_out=0.
- COUNT: confirm_out=1, show_digit=1.
  - tick increments each cycle.
  - When tick==TICKS_PER_SEC-1: tick=0. If digit==1 -> GO, else digit=digit-1.
  - Each digit is therefore visible for exactly TICKS_PER_SEC cycles.
  - If countdown_active drops mid-count (menu reset) -> IDLE, digit=0.
- GO: confirm_out=0 (menu enters PLAY on the next edge), show_digit=0, show_go=1, digit=0.
  - After GO_TICKS cycles in GO -> DONE.
- DONE: done=1 for exactly one cycle, show_go=0 -> IDLE.
- Menu timing: from the press edge to confirm_out=1 is one cycle. Total time from entering COUNT to entering GO is COUNT_FROM*TICKS_PER_SEC cycles.
- Simultaneous events: the abort condition (countdown_active low in COUNT) has priority over tick expiry.
- Re-arming: IDLE re-arms only while menu_active, so presses during PLAY do nothing.

Optional Feature:
COUNTDOWN_SKIP_EN:
- Defined: press_rise in COUNT jumps directly to GO on the next edge (tick=0, digit=0, confirm_out=0). The abort condition still has priority.
- Undefined: presses in COUNT are ignored and the countdown always runs full length.

Test Plan:
- Reset with btn_press=1, release reset, keep holding -> stays IDLE, confirm_out=0.
- menu_active=1, press at cycle 10 -> confirm_out=1 at 11. Raise countdown_active at 12 -> digit=3 at 13, 2 at 73, 1 at 133, show_go=1 and confirm_out=0 at 193, done pulse at 223.
- Override TICKS_PER_SEC=4, COUNT_FROM=1, GO_TICKS=2 -> digit 1 shown 4 cycles, GO shown 2 cycles, done high for exactly 1 cycle.
- Drop countdown_active while digit=2 -> next edge IDLE, confirm_out=0, digit=0, no done pulse.
- Assert reset asynchronously mid-GO -> outputs 0 immediately, without waiting for a clock edge.
- With COUNTDOWN_SKIP_EN, press during digit=3 -> show_go=1 next cycle, done after GO_TICKS. Without the macro the same press has no effect.
